// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared types for the radix-4 Booth multiplier family.
//   - state_t      : control states of the sequential engine (IDLE/RUN/DONE)
//   - booth_code_t : recoded digit selected by one 3-bit multiplier window
//   - booth_decode : maps a window {b[2k+1], b[2k], b[2k-1]} to its digit
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Recoded digit values: 0, +1, +2, -1, -2 times the multiplicand.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_code_t;

  function automatic booth_code_t booth_decode(input logic [2:0] window);
    booth_code_t code;
    case (window)
      3'b001, 3'b010: code = P1;
      3'b011:         code = P2;
      3'b100:         code = M2;
      3'b101, 3'b110: code = M1;
      default:        code = ZERO;  // 000 and 111
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// booth_r4_enc
//   Combinational radix-4 Booth digit encoder. Turns one 3-bit multiplier
//   window into the corresponding multiple of the multiplicand, in 2N-bit
//   two's complement. Shared with the fully parallel multiplier.
// Ports:
//   i_window   [2:0]     {mr[2k+1], mr[2k], mr[2k-1]}
//   i_md_ext   [2N-1:0]  multiplicand, already sign-extended to 2N bits
//   o_multiple [2N-1:0]  0, +md, +2md, -md or -2md
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]     i_window,
  input  logic [2*N-1:0] i_md_ext,
  output logic [2*N-1:0] o_multiple
);

  booth_code_t w_code;

  // The multiplicand arrives sign-extended so that 2*md and -2*md of the
  // most negative operand are still representable (e.g. -2*(-2^(N-1)) = 2^N).
  always_comb begin
    w_code     = booth_decode(i_window);
    o_multiple = '0;
    case (w_code)
      P1:      o_multiple = i_md_ext;
      P2:      o_multiple = i_md_ext << 1;
      M1:      o_multiple = -i_md_ext;
      M2:      o_multiple = -(i_md_ext << 1);
      default: o_multiple = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_arb.sv
// booth_r4_seq_arb
//   Iterative radix-4 Booth multiplier shared by two requesters. A round-robin
//   arbiter accepts one operand pair, then N/2 Booth windows are accumulated,
//   one partial product per clock, into a 2N-bit accumulator. The signed
//   product is returned with the owning requester's ID.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. Requesters may raise or drop req_valid at any time before
//   that edge. req_ready is combinational and only ever asserted in IDLE
//   (never during reset); out_valid/out_data/out_id are held stable until
//   out_ready is seen high.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-low reset
//   req_valid  [1:0]   per-requester operand valid
//   req_ready  [1:0]   per-requester accept (one-hot or zero)
//   req_md     [2N-1:0] multiplicands, requester i at [i*N +: N], signed
//   req_mr     [2N-1:0] multipliers, same packing, signed
//   out_valid  product available
//   out_ready  consumer accepts the product
//   out_data   [2N-1:0] signed product md*mr
//   out_id     requester that owns out_data
//   busy       high in RUN or DONE
//   dbg_state  [1:0]   current control state (booth_pkg::state_t encoding)
module booth_r4_seq_arb
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_md,
  input  logic [2*N-1:0] req_mr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_data,
  output logic           out_id,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  localparam int                 KW     = (N / 2 > 1) ? $clog2(N / 2) : 1;
  localparam logic [KW-1:0]      K_LAST = KW'(N / 2 - 1);

  state_t          r_state;
  state_t          w_next;

  logic [2*N-1:0]  r_md;      // sign-extended multiplicand
  logic [N-1:0]    r_mr;      // multiplier
  logic [2*N-1:0]  r_acc;
  logic [KW-1:0]   r_k;       // index of the window being added this cycle
  logic            r_id;
  logic            r_rr;      // requester with priority on a tie

  logic            w_grant_vld;
  logic            w_grant_id;
  logic            w_accept;
  logic [N-1:0]    w_sel_md;
  logic [N-1:0]    w_sel_mr;

  logic [N:0]      w_mr_ext;
  logic [N:0]      w_mr_sh;
  logic [2:0]      w_window;
  logic [2*N-1:0]  w_mult;
  logic [2*N-1:0]  w_mult_sh;
  logic [KW:0]     w_shamt;

  // ---------------------------------------------------------------------
  // Round-robin arbiter: r_rr wins ties, otherwise whoever is valid.
  // ---------------------------------------------------------------------
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = r_rr;
    if (req_valid[r_rr]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_rr;
    end else if (req_valid[~r_rr]) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ~r_rr;
    end
  end

  // No grant while reset is asserted so req_ready reads zero during reset.
  assign w_accept = (r_state == IDLE) && reset && w_grant_vld;

  assign w_sel_md = w_grant_id ? req_md[2*N-1:N] : req_md[N-1:0];
  assign w_sel_mr = w_grant_id ? req_mr[2*N-1:N] : req_mr[N-1:0];

  // ---------------------------------------------------------------------
  // Booth window k = {mr[2k+1], mr[2k], mr[2k-1]} with mr[-1] = 0:
  // append a zero below the LSB and shift the window down to bit 0.
  // ---------------------------------------------------------------------
  assign w_shamt   = {r_k, 1'b0};
  assign w_mr_ext  = {r_mr, 1'b0};
  assign w_mr_sh   = w_mr_ext >> w_shamt;
  assign w_window  = w_mr_sh[2:0];

  booth_r4_enc #(
    .N(N)
  ) u_enc (
    .i_window   (w_window),
    .i_md_ext   (r_md),
    .o_multiple (w_mult)
  );

  // Weight of window k is 4^k; the sum wraps modulo 2^(2N) by width.
  assign w_mult_sh = w_mult << w_shamt;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (r_k == K_LAST) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready = 2'b00;
    if (w_accept) begin
      req_ready[w_grant_id] = 1'b1;
    end
    out_valid = (r_state == DONE);
    out_data  = (r_state == DONE) ? r_acc : '0;
    out_id    = (r_state == DONE) ? r_id : 1'b0;
    busy      = (r_state == RUN) || (r_state == DONE);
    dbg_state = r_state;
  end

  // ---------------------------------------------------------------------
  // Operand latch, window counter, accumulator and arbitration pointer.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_md  <= '0;
      r_mr  <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_id  <= 1'b0;
      r_rr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_md  <= {{N{w_sel_md[N-1]}}, w_sel_md};
            r_mr  <= w_sel_mr;
            r_acc <= '0;
            r_k   <= '0;
            r_id  <= w_grant_id;
            r_rr  <= ~w_grant_id;
          end
        end
        RUN: begin
          r_acc <= r_acc + w_mult_sh;
          r_k   <= r_k + KW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_arb.sv
// Bench for booth_r4_seq_arb (N = 32). Inputs are driven 1 time unit after
// each rising edge; the model and checks run on the falling edge, where the
// inputs already hold the values the next rising edge will sample.
module tb_booth_r4_seq_arb;
  import booth_pkg::*;

  localparam int N = 32;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_md;
  logic [2*N-1:0] req_mr;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_data;
  logic           out_id;
  logic           busy;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  booth_r4_seq_arb #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_md    (req_md),
    .req_mr    (req_mr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*N:0] exp_q[$];   // {id, product}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*N-1:0] golden(input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // Round-robin grant: a single valid wins, a tie goes to the pointer.
  function automatic logic [1:0] model_grant(input logic [1:0] v, input bit rr);
    if (v == 2'b11) return rr ? 2'b10 : 2'b01;
    return v;
  endfunction

  // ---------------- behavioural model + compare process ----------------
  bit mon_en = 0;
  int m_phase = 0;        // 0 idle, 1 computing, 2 result offered
  int m_cnt = 0;          // cycles spent computing
  bit m_rr = 0;
  int n_acc = 0;
  int last_acc_cyc = 0;
  int last_acc_id = 0;
  int last_hs_cyc = 0;

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic       gid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    exp_rdy = 2'b00;
    if (mon_en && m_phase == 0 && reset) exp_rdy = model_grant(req_valid, m_rr);
    if (mon_en) begin
      chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
      chk("busy", {63'd0, busy}, {63'd0, m_phase != 0});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
      if (m_phase == 2) begin
        if (exp_q.size() == 0) begin
          chk("sb_nothing_expected", 64'd1, 64'd0);
        end else begin
          chk("out_data", out_data, exp_q[0][2*N-1:0]);
          chk("out_id", {63'd0, out_id}, {63'd0, exp_q[0][2*N]});
        end
      end
    end
    // Predict the effect of the coming rising edge.
    if (!reset) begin
      mon_en  = 1;
      m_phase = 0;
      m_rr    = 0;
      exp_q.delete();
    end else if (mon_en) begin
      case (m_phase)
        0: if (exp_rdy != 2'b00) begin
          gid = exp_rdy[1];
          a = gid ? req_md[2*N-1:N] : req_md[N-1:0];
          b = gid ? req_mr[2*N-1:N] : req_mr[N-1:0];
          exp_q.push_back({gid, golden(a, b)});
          m_rr = ~gid;
          m_phase = 1;
          m_cnt = 0;
          n_acc++;
          last_acc_cyc = cyc + 1;
          last_acc_id = int'(gid);
        end
        1: begin
          m_cnt++;
          if (m_cnt == N / 2) m_phase = 2;
        end
        default: if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_phase = 0;
          last_hs_cyc = cyc + 1;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [N-1:0] md, input logic [N-1:0] mr);
    if (id == 0) begin
      req_md[N-1:0] = md;
      req_mr[N-1:0] = mr;
    end else begin
      req_md[2*N-1:N] = md;
      req_mr[2*N-1:N] = mr;
    end
  endtask

  task automatic wait_acc(input int n0);
    int i;
    i = 0;
    while (n_acc == n0 && i < 200) begin
      tick();
      i++;
    end
    if (n_acc == n0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input int id, input logic [N-1:0] md, input logic [N-1:0] mr);
    int n0;
    n0 = n_acc;
    set_op(id, md, mr);
    req_valid[id] = 1'b1;
    wait_acc(n0);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_out();
    int i;
    i = 0;
    while (out_valid !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    if (out_valid !== 1'b1) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  localparam logic [63:0] ARB_DATA [4] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_02BC,
                                           64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_02BC};
  initial begin
    logic [2*N-1:0] held;
    int n0;
    int target;
    int i;
    reset = 1'b0; req_valid = 2'b00; req_md = '0; req_mr = '0; out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_id", {63'd0, out_id}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});

    // Accept timing: 7 * -3
    reset = 1'b1;
    set_op(0, 32'd7, 32'hFFFF_FFFD);
    req_valid = 2'b01;
    out_ready = 1'b1;
    #1;
    chk("t1_ready", {62'd0, req_ready}, 64'd1);
    wait_acc(n_acc);
    chk("t1_ready_one_cycle", {62'd0, req_ready}, 64'd0);
    req_valid = 2'b00;
    wait_out();
    chk("t1_latency", 64'(cyc - last_acc_cyc), 64'd16);
    chk("t1_data", out_data, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t1_id", {63'd0, out_id}, 64'd0);
    tick();

    // Corner operands
    issue(0, 32'h8000_0000, 32'h8000_0000);
    wait_out();
    chk("min_x_min", out_data, 64'h4000_0000_0000_0000);
    tick();
    issue(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_out();
    chk("max_x_max", out_data, 64'h3FFF_FFFF_0000_0001);
    chk("max_x_max_id", {63'd0, out_id}, 64'd1);
    tick();
    issue(0, 32'h0, 32'hFFFF_FFFF);
    wait_out();
    chk("zero_x_m1", out_data, 64'd0);
    tick();

    // Backpressure: result held 5 cycles while another request waits
    out_ready = 1'b0;
    issue(1, 32'd1000, 32'hFFFF_FFFD);
    set_op(0, 32'd5, 32'd6);
    req_valid = 2'b01;
    wait_out();
    held = out_data;
    chk("bp_data", held, 64'hFFFF_FFFF_FFFF_F448);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("bp_data_hold", out_data, held);
      chk("bp_no_ready", {62'd0, req_ready}, 64'd0);
    end
    n0 = n_acc;
    out_ready = 1'b1;
    wait_acc(n0);
    chk("bp_next_accept", 64'(last_acc_cyc - last_hs_cyc), 64'd1);
    req_valid = 2'b00;
    wait_out();
    chk("bp_second", out_data, 64'd30);
    tick();

    // Mid-run reset at k=7 with requester 0 in flight (pointer then favours 1)
    issue(0, 32'd123, 32'd456);
    repeat (7) tick();
    reset = 1'b0;
    tick();
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_state", {62'd0, dbg_state}, {62'd0, IDLE});
    reset = 1'b1;

    // Arbitration after reset: both valid held -> 0,1,0,1
    set_op(0, 32'd3, 32'hFFFF_FFFB);
    set_op(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_acc(n_acc);
      chk("arb_grant", 64'(last_acc_id), 64'(k % 2));
      wait_out();
      chk("arb_out_id", {63'd0, out_id}, 64'(k % 2));
      chk("arb_data", out_data, ARB_DATA[k]);
    end
    req_valid = 2'b00;
    tick();

    // Requester 1 alone
    issue(1, 32'd12345, 32'hFFFF_FFFE);
    wait_out();
    chk("r1_data", out_data, 64'hFFFF_FFFF_FFFF_9F8E);
    chk("r1_id", {63'd0, out_id}, 64'd1);
    tick();

    // Random traffic with random valid and ready gaps
    target = n_acc + 2000;
    while (n_acc < target && cyc < 95000) begin
      tick();
      req_valid = 2'($urandom_range(0, 3));
      set_op(0, rnd_op(), rnd_op());
      set_op(1, rnd_op(), rnd_op());
      out_ready = ($urandom_range(0, 3) != 0);
    end
    if (n_acc < target) chk("random_budget", 64'(n_acc), 64'(target));
    req_valid = 2'b00;
    out_ready = 1'b1;
    i = 0;
    while ((exp_q.size() != 0 || m_phase != 0) && i < 200) begin
      tick();
      i++;
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_arb.md
Name: booth_r4_seq_arb

Overview:
- Iterative radix-4 Booth multiply engine shared between two requesters.
- Round-robin arbiter grants one operand pair, then sequences N/2 Booth windows, one partial product per clock, into a 2N-bit accumulator.
- Returns the signed product with the requester ID over a valid/ready output handshake.
- Serves as the area-lean alternative to the fully parallel multiplier, for blocks that can tolerate multi-cycle latency.

Parameters:
- N, 32, operand width; must be even and >= 4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- req_valid  in  2  per-requester operand valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_md  in  2*N  multiplicands, signed; requester i uses bits [i*N +: N].
- req_mr  in  2*N  multipliers, signed; same packing as req_md.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- out_data  out  2*N  signed product md*mr.
- out_id  out  1  index of the requester that owns out_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (reset==0 at posedge), including mid-operation:
  - state=IDLE, acc=0, k=0, rr_ptr=0.
  - out_valid=0, out_data=0, out_id=0, busy=0, req_ready=0.
  - An in-flight operation is discarded; nothing is returned for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational, driven only in IDLE.
  - Grant goes to requester rr_ptr if its valid is high, else to the other requester if its valid is high.
  - req_ready[grant]=1; the other bit is 0.
  - On an accept edge (valid && ready): latch md and mr sign-extended to 2N bits, latch id, acc=0, k=0, rr_ptr=~id, go to RUN.
- RUN, cycle k (0..N/2-1):
  - Window w = {mr[2k+1], mr[2k], mr[2k-1]}, with mr[-1]=0.
  - Encode: 000/111 -> 0, 001/010 -> +md, 011 -> +2md, 100 -> -2md, 101/110 -> -md.
  - Form the multiple in 2N-bit two's complement, shift left by 2k, add to acc modulo 2^(2N).
  - At k=N/2-1, go to DONE on the same edge.
- DONE:
  - out_valid=1; out_data=acc; out_id=latched id.
  - All outputs hold stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0.
- Latency: out_valid rises exactly N/2 clocks after the accept edge (16 for N=32).
  - Minimum issue interval is N/2+2 clocks: accept, N/2 RUN cycles, DONE with immediate ready, then IDLE.
- No new accept while busy; req_ready=0 in RUN and DONE.
- Requesters may hold or drop req_valid freely before the accept edge (no stickiness required).
- Arithmetic boundaries:
  - md = -2^(N-1) with w=100 must produce +2^N correctly; this is why the operands are sign-extended before forming 2md.
  - The full product range fits in 2N bits; no overflow flag.
- Simultaneous valid on both requesters: rr_ptr decides. After reset, requester 0 wins first.
- Grant fairness: a requester that continuously asserts valid is granted within two operations.

Decomposition:
- Shared package booth_pkg: state enum (IDLE/RUN/DONE) and the Booth code constants (ZERO, P1, P2, M1, M2).
- Sub-module booth_r4_enc: combinational; window[2:0] plus sign-extended md[2N-1:0] in, multiple[2N-1:0] out.
  - Reusable by the parallel multiplier.
- The arbiter, FSM, counter and accumulator stay in the top module.

Test Plan:
- Accept timing (N=32): reset low 2 cycles, then req_valid=01, md=7, mr=-3, out_ready=1 -> req_ready=01 for one cycle; out_valid exactly 16 cycles after accept; out_data=64'hFFFF_FFFF_FFFF_FFEB, out_id=0.
- Corner operands: md=mr=32'h8000_0000 -> 64'h4000_0000_0000_0000. md=mr=32'h7FFF_FFFF -> 64'h3FFF_FFFF_0000_0001. md=0, mr=-1 -> 0.
- Arbitration: req_valid=11 held for 4 operations -> grants alternate 0,1,0,1; out_id matches each grant; no req_ready pulse while busy.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable; req_ready stays 00. Then out_ready=1 -> IDLE, and the next accept occurs one cycle later.
- Mid-run reset: assert reset=0 at k=7 -> the following posedge gives state IDLE, busy=0, out_valid=0. Then a new request from requester 1 alone completes correctly, and rr_ptr restarted at 0.
- Random: 2000 random signed pairs with random valid/ready gaps -> out_data equals the golden signed product; every accepted request is returned exactly once with the correct out_id.
